// File: rtl/output_byte_mux.sv
// Streams each memory line out as W-bit beats with valid/ready handshaking, then
// pulses the active-low read advance once per beat so the memory steps to the next line.
module output_byte_mux #(
  parameter int ADC_MAX_DATA_SIZE = 16,
  parameter int BRAM_WORD_NUM     = 16
) (
  input  logic                                   i_out_mux_clk,
  input  logic                                   i_out_mux_reset_n,
  input  logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] i_out_mux_rd_data,
  output logic                                   o_out_mux_rd_en_n,
  input  logic                                   i_out_mux_start,
  input  logic                                   i_out_mux_abort,
  input  logic [12:0]                            i_out_mux_line_count,
  output logic [ADC_MAX_DATA_SIZE/2-1:0]         o_out_mux_data,
  output logic                                   o_out_mux_valid,
  input  logic                                   i_out_mux_ready,
  output logic                                   o_out_mux_busy,
  output logic                                   o_out_mux_done
);

  localparam int W  = ADC_MAX_DATA_SIZE / 2;
  localparam int NB = 2 * BRAM_WORD_NUM;
  localparam int LW = ADC_MAX_DATA_SIZE * BRAM_WORD_NUM;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH1, FETCH2, CAPTURE, SEND, ADVANCE, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [12:0]     remaining_q, remaining_d;
  logic [LW-1:0]   line_q, line_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [BW-1:0]   adv_q, adv_d;
  logic [W-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            rd_en_n_q, rd_en_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_ff @(posedge i_out_mux_clk or negedge i_out_mux_reset_n) begin
    if (!i_out_mux_reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      adv_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      rd_en_n_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      adv_q       <= adv_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rd_en_n_q   <= rd_en_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    line_d      = line_q;
    beat_d      = beat_q;
    adv_d       = adv_q;
    data_d      = data_q;
    valid_d     = valid_q;
    rd_en_n_d   = rd_en_n_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_out_mux_start) begin
          remaining_d = i_out_mux_line_count;
          if (i_out_mux_line_count == 13'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH1;
          end
        end
      end
      FETCH1:  state_d = FETCH2;
      FETCH2:  state_d = CAPTURE;
      CAPTURE: begin
        line_d      = i_out_mux_rd_data;
        beat_d      = '0;
        remaining_d = remaining_q - 13'd1;
        data_d      = i_out_mux_rd_data[W-1:0];
        valid_d     = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (valid_q && i_out_mux_ready) begin
          if (beat_q == LAST) begin
            valid_d   = 1'b0;
            rd_en_n_d = 1'b0;
            adv_d     = '0;
            state_d   = ADVANCE;
          end else begin
            // The line register shifts down so the next beat is always in bits [2W-1:W].
            beat_d = beat_q + BW'(1);
            line_d = line_q >> W;
            data_d = line_q[2*W-1:W];
          end
        end
      end
      ADVANCE: begin
        if (adv_q == LAST) begin
          rd_en_n_d = 1'b1;
          if (remaining_q != 13'd0) begin
            state_d = FETCH1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          adv_d = adv_q + BW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (i_out_mux_abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      rd_en_n_d = 1'b1;
      done_d    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign o_out_mux_rd_en_n = rd_en_n_q;
  assign o_out_mux_data    = data_q;
  assign o_out_mux_valid   = valid_q;
  assign o_out_mux_busy    = busy_q;
  assign o_out_mux_done    = done_q;

endmodule

// File: tb/tb_output_byte_mux.sv
// Scoreboard bench for output_byte_mux at W=8, NB=32: stimulus queues expected beats,
// a forked negedge monitor pops and compares each handshake and tracks read bursts.
module tb_output_byte_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] rd_data;
  logic         rd_en_n;
  logic         start;
  logic         abort;
  logic [12:0]  line_count;
  logic [7:0]   data;
  logic         valid;
  logic         ready;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  output_byte_mux #(
    .ADC_MAX_DATA_SIZE(16),
    .BRAM_WORD_NUM(16)
  ) dut (
    .i_out_mux_clk(clk),
    .i_out_mux_reset_n(rst_n),
    .i_out_mux_rd_data(rd_data),
    .o_out_mux_rd_en_n(rd_en_n),
    .i_out_mux_start(start),
    .i_out_mux_abort(abort),
    .i_out_mux_line_count(line_count),
    .o_out_mux_data(data),
    .o_out_mux_valid(valid),
    .i_out_mux_ready(ready),
    .o_out_mux_busy(busy),
    .o_out_mux_done(done)
  );

  // Memory model: one line per 32 read-advance clocks; byte k of line L is L*32+k.
  int rd_cnt = 0;
  always @(posedge clk) if (!rd_en_n) rd_cnt <= rd_cnt + 1;
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < 32; k++) rd_data[k*8 +: 8] = 8'((rd_cnt / 32) * 32 + k);
  end

  logic [7:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int mon_beats = 0, mon_valid = 0, mon_rdlow = 0, mon_bursts = 0, mon_done = 0;
  int cur_len = 0;
  bit burst_chk = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic monitor();
    logic       prev_valid = 1'b0;
    logic       prev_xfer  = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       xfer;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (valid) mon_valid++;
      if (prev_valid && !prev_xfer && valid) check("stall_hold", data, prev_data);
      xfer = valid && ready && !abort && rst_n;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL beat: got unexpected beat %0d, scoreboard empty", data);
        end else begin
          e = exp_q.pop_front();
          check("beat", data, e);
        end
        mon_beats++;
      end
      prev_valid = valid;
      prev_xfer  = xfer;
      prev_data  = data;
      if (!rd_en_n) begin
        mon_rdlow++;
        cur_len++;
      end else if (cur_len > 0) begin
        mon_bursts++;
        if (burst_chk) check("burst_len", cur_len, 32);
        cur_len = 0;
      end
      if (done) mon_done++;
    end
  endtask

  task automatic run(input int n, input bit toggle, input int abort_at, input int rst_at,
                     input string tag);
    int b0, v0, r0, bu0, d0, base, cyc, first_v, done_cyc, busy_bad, adv_cyc;
    bit fin;
    b0 = mon_beats; v0 = mon_valid; r0 = mon_rdlow; bu0 = mon_bursts; d0 = mon_done;
    base = rd_cnt / 32;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 32; k++) exp_q.push_back(8'((base + i) * 32 + k));
    @(posedge clk); #1;
    start = 1'b1; line_count = 13'(n); ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; first_v = -1; done_cyc = -1; busy_bad = 0; adv_cyc = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else if (!busy) busy_bad++;
      if (toggle && cyc == 10) begin
        start = 1'b1;
        line_count = 13'd5;
      end else if (toggle && cyc == 11) start = 1'b0;
      if (!fin && abort_at > 0 && (mon_beats - b0) == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en_n"}, rd_en_n, 1);
        check({tag, "_done"}, done, 0);
        fin = 1'b1;
      end
      if (!fin && rst_at > 0 && !rd_en_n) begin
        adv_cyc++;
        if (adv_cyc == rst_at) begin
          burst_chk = 1'b0;
          #2;
          rst_n = 1'b0;
          start = 1'b1;
          #1;
          check({tag, "_rd_en_n"}, rd_en_n, 1);
          check({tag, "_valid"}, valid, 0);
          check({tag, "_busy"}, busy, 0);
          check({tag, "_done"}, done, 0);
          check({tag, "_data"}, data, 0);
          repeat (2) @(posedge clk);
          #1;
          check({tag, "_busy_in_reset"}, busy, 0);
          rst_n = 1'b1;
          start = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          check({tag, "_idle_busy"}, busy, 0);
          check({tag, "_idle_valid"}, valid, 0);
          burst_chk = 1'b1;
          fin = 1'b1;
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
        if (toggle) ready = ~ready;
      end
    end
    if (abort_at > 0) begin
      check({tag, "_beats"}, mon_beats - b0, abort_at);
      check({tag, "_sb_left"}, exp_q.size(), n * 32 - abort_at);
      @(posedge clk); #1;
      check({tag, "_no_done"}, mon_done - d0, 0);
      exp_q.delete();
    end else if (rst_at > 0) begin
      check({tag, "_beats"}, mon_beats - b0, n * 32);
      check({tag, "_no_done"}, mon_done - d0, 0);
    end else begin
      check({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
      if (n > 0) check({tag, "_first_valid"}, first_v, 3);
      else check({tag, "_done_cyc"}, done_cyc, 0);
      check({tag, "_busy_drop"}, busy_bad, 0);
      @(posedge clk); #1;
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_done_pulses"}, mon_done - d0, 1);
      check({tag, "_beats"}, mon_beats - b0, n * 32);
      check({tag, "_bursts"}, mon_bursts - bu0, n);
      check({tag, "_rd_low"}, mon_rdlow - r0, n * 32);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
      if (!toggle) check({tag, "_valid_cycles"}, mon_valid - v0, n * 32);
    end
    $display("run %s: lines=%0d beats=%0d checks=%0d passed=%0d",
             tag, n, mon_beats - b0, chk_cnt, pass_cnt);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; line_count = '0;
    fork
      monitor();
    join_none
    @(posedge clk); #1;
    check("reset_rd_en_n", rd_en_n, 1);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run(1, 1'b0, 0, 0, "single");
    run(1, 1'b1, 0, 0, "toggle");
    run(3, 1'b0, 0, 0, "three");
    run(0, 1'b0, 0, 0, "zero");
    run(1, 1'b0, 10, 0, "abort");
    run(1, 1'b0, 0, 0, "restart");
    run(1, 1'b0, 0, 5, "reset");
    run(2, 1'b0, 0, 0, "post_reset");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
